hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Issue-side partner of the EX-stage forwarding logic.
- Shadows the destination register of every in-flight instruction in the EX, MEM and WB stages.
- Decides when a decoded instruction may enter EX:
  - forwarding is sufficient → issue;
  - load-use hazard → stall;
  - taken branch → flush;
  - data-memory wait → freeze the whole pipeline.
- Sits beside the ID stage and drives the stall/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle counter
- FLUSH_CNT_W, 16, width of the saturating flush counter

Ports:
- clk  in  1  pipeline clock
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  5  ID destination
- id_reg_write  in  1  ID writes rd
- id_mem_to_reg  in  2  00 ALU, 01 imm, 10 PC+4, 11 load
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  MEM stage accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- freeze_back  out  1  hold ID/EX, EX/MEM, MEM/WB
- flush_if_id  out  1  zero IF/ID
- flush_id_ex  out  1  insert bubble into ID/EX
- pending  out  32  bit r set when an in-flight slot will write r (bit 0 always 0)
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall_if=1
- flush_count  out  FLUSH_CNT_W  saturating count of cycles with flush_if_id=1

Behaviour:
- State: three tag slots, EX, MEM and WB, each holding {v, rd, ld}.
  - ld = (mem_to_reg==11).
  - A slot counts only when v && rd!=0 && reg_write was set on entry.
- Reset (rstn=0, async): all slots v=0; every output 0; counters 0. Deassertion takes effect on the next clk edge.
- Conditions, all evaluated combinationally each cycle:
  - memwait = MEM.v && mem_req && !mem_ready.
  - loaduse = id_valid && EX.v && EX.ld && EX.rd!=0 && ((id_use_rs1 && id_rs1==EX.rd) || (id_use_rs2 && id_rs2==EX.rd)).
  - A match against MEM or WB never stalls; forwarding covers it.
- Priority and outputs:
  - memwait: stall_if=stall_id=freeze_back=1; flush_*=0; slots hold. A pending ex_branch_taken is ignored this cycle and must be held by EX until the freeze ends.
  - Else ex_branch_taken: flush_if_id=flush_id_ex=1; stalls 0. Next edge: WB<=MEM, MEM<=EX, EX<=bubble (v=0). Branch overrides loaduse.
  - Else loaduse: stall_if=stall_id=1, flush_id_ex=1. Next edge: shift as above with EX<=bubble. Stall lasts exactly 1 cycle per load-use pair.
  - Else normal: WB<=MEM, MEM<=EX, EX<={id_valid&&id_reg_write, id_rd, id_mem_to_reg==11}.
- pending: OR of one-hot(rd) across counting slots; registered view of current slots, no same-cycle ID term.
- Counters:
  - stall_cycles increments on every clk edge where stall_if=1.
  - flush_count increments on every edge where flush_if_id=1.
  - Both saturate at all-ones; no wrap.
- Outputs are combinational from slot state and inputs. Slots and counters are the only flops.
- Reset mid-freeze or mid-stall: clears immediately; no residual stall after rstn rises.

Test Plan:
- Load x5 then add x6,x5,x1 back-to-back → one cycle stall_if=stall_id=flush_id_ex=1; EX slot bubble; add issues next cycle; stall_cycles=1.
- Load x5, independent instr, add using x5 → no stall (MEM match is forwarded); pending[5]=1 for 3 cycles after load issue.
- Load x0 then use x0 → no stall; pending=0.
- MEM slot mem_req=1, mem_ready low 3 cycles → stall_if=stall_id=freeze_back=1 for exactly 3 cycles; slots unchanged; stall_cycles+=3.
- ex_branch_taken coincident with loaduse → flush_if_id=flush_id_ex=1, stall_if=0; flush_count=1; EX bubble.
- Drive stall for 2^STALL_CNT_W+5 cycles with STALL_CNT_W=4 → stall_cycles sticks at 15. Assert rstn=0 mid-memwait → all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard control beside ID: shadows EX/MEM/WB destination tags and
// drives stall, flush and freeze for the pipeline registers.
module hazard_scoreboard #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [4:0]             id_rd,
  input  logic                   id_reg_write,
  input  logic [1:0]             id_mem_to_reg,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   freeze_back,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic [31:0]            pending,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);
  localparam int SLOTS = 3;
  localparam int EX    = 0;
  localparam int MEM   = 1;
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};

  // Slot 0 = EX, 1 = MEM, 2 = WB; r_v already folds in reg_write at entry.
  logic [SLOTS-1:0]       r_v;
  logic [SLOTS-1:0]       r_ld;
  logic [4:0]             r_rd [SLOTS];
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;

  logic        w_memwait;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic        w_loaduse;
  logic        w_flush;
  logic        w_lu_stall;
  logic        w_bubble;
  logic [31:0] w_onehot [SLOTS];
  logic [31:0] w_pending;

  assign w_memwait  = r_v[MEM] && mem_req && !mem_ready;
  assign w_rs1_hit  = id_use_rs1 && (id_rs1 == r_rd[EX]);
  assign w_rs2_hit  = id_use_rs2 && (id_rs2 == r_rd[EX]);
  assign w_loaduse  = id_valid && r_v[EX] && r_ld[EX] && (r_rd[EX] != 5'd0) &&
                      (w_rs1_hit || w_rs2_hit);
  // A taken branch outranks load-use; memwait outranks both and defers the branch.
  assign w_flush    = !w_memwait && ex_branch_taken;
  assign w_lu_stall = !w_memwait && !ex_branch_taken && w_loaduse;
  assign w_bubble   = ex_branch_taken || w_loaduse;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign w_onehot[gi] = (r_v[gi] && (r_rd[gi] != 5'd0)) ? (32'd1 << r_rd[gi]) : 32'd0;
    end
  endgenerate

  assign w_pending = w_onehot[0] | w_onehot[1] | w_onehot[2];

  // Gating with rstn keeps every output low while reset is held, even with live inputs.
  assign stall_if     = rstn && (w_memwait || w_lu_stall);
  assign stall_id     = rstn && (w_memwait || w_lu_stall);
  assign freeze_back  = rstn && w_memwait;
  assign flush_if_id  = rstn && w_flush;
  assign flush_id_ex  = rstn && (w_flush || w_lu_stall);
  assign pending      = rstn ? w_pending : 32'd0;
  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v  <= '0;
      r_ld <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_rd[i] <= 5'd0;
      end
    end else if (!w_memwait) begin
      r_v     <= {r_v[1:0], !w_bubble && id_valid && id_reg_write};
      r_ld    <= {r_ld[1:0], !w_bubble && (id_mem_to_reg == 2'b11)};
      r_rd[2] <= r_rd[1];
      r_rd[1] <= r_rd[0];
      r_rd[0] <= w_bubble ? 5'd0 : id_rd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_if && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_ONE;
      end
      if (flush_if_id && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + FLUSH_ONE;
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, multi-cycle corner sequences,
// then random traffic against a queue-based pipeline model.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write;
  logic        ex_branch_taken, mem_req, mem_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_mem_to_reg;

  logic        stall_if, stall_id, freeze_back, flush_if_id, flush_id_ex;
  logic [31:0] pending;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  logic        s_stall_if, s_stall_id, s_freeze_back, s_flush_if_id, s_flush_id_ex;
  logic [31:0] s_pending;
  logic [3:0]  s_stall_cycles;
  logic [3:0]  s_flush_count;

  logic [4:0]  ctl, s_ctl;
  assign ctl   = {stall_if, stall_id, freeze_back, flush_if_id, flush_id_ex};
  assign s_ctl = {s_stall_if, s_stall_id, s_freeze_back, s_flush_if_id, s_flush_id_ex};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .freeze_back(freeze_back),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pending(pending),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_scoreboard #(.STALL_CNT_W(4), .FLUSH_CNT_W(4)) u_sat (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .freeze_back(s_freeze_back),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .pending(s_pending),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] m2r;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [4:0] e_ctl;
    logic [31:0] e_pend;
    int         e_stall;
    int         e_flush;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } slot_t;

  function automatic vec_t mkv(input int v, input int rs1, input int u1, input int rs2,
                               input int u2, input int rd, input int rw, input int m2r,
                               input int br, input int mreq, input int mrdy, input int e_ctl,
                               input int e_pend, input int e_stall, input int e_flush);
    vec_t t;
    t.v = 1'(v);     t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
    t.rd = 5'(rd);   t.rw = 1'(rw);   t.m2r = 2'(m2r);
    t.br = 1'(br);   t.mreq = 1'(mreq); t.mrdy = 1'(mrdy);
    t.e_ctl = 5'(e_ctl); t.e_pend = 32'(e_pend); t.e_stall = e_stall; t.e_flush = e_flush;
    return t;
  endfunction

  function automatic vec_t nopv(input int br, input int mreq, input int mrdy, input int e_ctl,
                                input int e_pend, input int e_stall, input int e_flush);
    return mkv(0, 0, 0, 0, 0, 0, 0, 0, br, mreq, mrdy, e_ctl, e_pend, e_stall, e_flush);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v;  id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd;    id_reg_write = t.rw; id_mem_to_reg = t.m2r;
    ex_branch_taken = t.br; mem_req = t.mreq; mem_ready = t.mrdy;
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, ".ctl"},   64'(ctl),          64'(t.e_ctl));
    chk({tag, ".pend"},  64'(pending),      64'(t.e_pend));
    chk({tag, ".stall"}, 64'(stall_cycles), 64'(t.e_stall));
    chk({tag, ".flush"}, 64'(flush_count),  64'(t.e_flush));
    $display("[TB] %s ctl=%b pend=%h stall=%0d flush=%0d", tag, ctl, pending,
             stall_cycles, flush_count);
  endtask

  vec_t  tbl [16];
  slot_t pipe [$];
  longint m_stall, m_flush, m_sstall, m_sflush;

  initial begin
    // Load-use, forwarded MEM match, and x0 destination scenarios (ctl = {sif,sid,frz,fif,fie}).
    tbl[0]  = mkv(1, 2, 1, 0, 0, 5, 1, 3, 0, 0, 0, 5'b00000, 'h0,   0, 0);
    tbl[1]  = mkv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 5'b11001, 'h20,  0, 0);
    tbl[2]  = mkv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 5'b00000, 'h20,  1, 0);
    tbl[3]  = nopv(0, 0, 0, 0, 'h60, 1, 0);
    tbl[4]  = nopv(0, 0, 0, 0, 'h40, 1, 0);
    tbl[5]  = nopv(0, 0, 0, 0, 'h40, 1, 0);
    tbl[6]  = mkv(1, 0, 0, 0, 0, 5, 1, 3, 0, 0, 0, 0, 'h0,   1, 0);
    tbl[7]  = mkv(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0, 0, 'h20,  1, 0);
    tbl[8]  = mkv(1, 5, 1, 5, 1, 8, 1, 0, 0, 0, 0, 0, 'hA0,  1, 0);
    tbl[9]  = nopv(0, 0, 0, 0, 'h1A0, 1, 0);
    tbl[10] = nopv(0, 0, 0, 0, 'h180, 1, 0);
    tbl[11] = nopv(0, 0, 0, 0, 'h100, 1, 0);
    tbl[12] = mkv(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 'h0, 1, 0);
    tbl[13] = mkv(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 'h0, 1, 0);
    tbl[14] = nopv(0, 0, 0, 0, 'h0, 1, 0);
    tbl[15] = nopv(0, 0, 0, 0, 'h0, 1, 0);

    rstn = 1'b0;
    drive(nopv(1, 1, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ctl",   64'(ctl),          64'd0);
    chk("reset.pend",  64'(pending),      64'd0);
    chk("reset.stall", 64'(stall_cycles), 64'd0);
    chk("reset.flush", 64'(flush_count),  64'd0);
    drive(nopv(0, 0, 0, 0, 0, 0, 0));
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Memory wait: three frozen cycles, a branch during the freeze is ignored.
    run_vec("mw0", mkv(1, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 'h0, 1, 0));
    run_vec("mw1", nopv(0, 0, 0, 0,        'h8, 1, 0));
    run_vec("mw2", nopv(0, 1, 0, 5'b11100, 'h8, 1, 0));
    run_vec("mw3", nopv(1, 1, 0, 5'b11100, 'h8, 2, 0));
    run_vec("mw4", nopv(0, 1, 0, 5'b11100, 'h8, 3, 0));
    run_vec("mw5", nopv(0, 1, 1, 0,        'h8, 4, 0));
    run_vec("mw6", nopv(0, 0, 0, 0,        'h8, 4, 0));

    // Branch coincident with load-use: flush wins, EX becomes a bubble.
    run_vec("br0", mkv(1, 0, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 'h0, 4, 0));
    run_vec("br1", mkv(1, 4, 1, 1, 1, 5, 1, 0, 1, 0, 0, 5'b00011, 'h10, 4, 0));
    run_vec("br2", nopv(0, 0, 0, 0, 'h10, 4, 1));
    run_vec("br3", nopv(0, 0, 0, 0, 'h10, 4, 1));

    // Long freeze drives the 4-bit counter into saturation.
    run_vec("sat_a", mkv(1, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 'h0, 4, 1));
    run_vec("sat_b", nopv(0, 0, 0, 0, 'h4, 4, 1));
    for (int k = 0; k < 21; k++) begin
      run_vec($sformatf("sat%0d", k), nopv(0, 1, 0, 5'b11100, 'h4, 4 + k, 1));
      chk($sformatf("sat%0d.small", k), 64'(s_stall_cycles), 64'((4 + k > 15) ? 15 : 4 + k));
    end
    @(negedge clk);
    #1;
    chk("sat.main",  64'(stall_cycles),   64'd25);
    chk("sat.small", 64'(s_stall_cycles), 64'd15);
    chk("sat.frz",   64'(ctl),            64'b11100);

    // Asynchronous reset in the middle of the freeze, with a branch request live.
    rstn = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    chk("arst.ctl",   64'(ctl),            64'd0);
    chk("arst.pend",  64'(pending),        64'd0);
    chk("arst.stall", 64'(stall_cycles),   64'd0);
    chk("arst.flush", 64'(flush_count),    64'd0);
    chk("arst.sctl",  64'(s_ctl),          64'd0);
    chk("arst.sstl",  64'(s_stall_cycles), 64'd0);
    $display("[TB] async reset ctl=%b stall=%0d", ctl, stall_cycles);
    @(negedge clk);
    ex_branch_taken = 1'b0;
    rstn = 1'b1;
    #1;
    chk("arst.rel", 64'(ctl), 64'd0);
    run_vec("arst.post", nopv(0, 1, 0, 0, 'h0, 0, 0));

    // Random traffic against the queue model.
    @(negedge clk);
    rstn = 1'b0;
    drive(nopv(0, 0, 0, 0, 0, 0, 0));
    #2;
    rstn = 1'b1;
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back('{v: 1'b0, rd: 0, ld: 1'b0});
    m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      slot_t ex, mem;
      bit mw, lu;
      logic [4:0]  e_ctl;
      logic [31:0] e_pend;
      @(negedge clk);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      id_rd           = 5'($urandom_range(0, 7));
      id_reg_write    = ($urandom_range(0, 3) != 0);
      id_mem_to_reg   = 2'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 2) != 0);
      #1;
      ex  = pipe[0];
      mem = pipe[1];
      mw  = mem.v && mem_req && !mem_ready;
      lu  = id_valid && ex.v && ex.ld && (ex.rd != 0) &&
            ((id_use_rs1 && int'(id_rs1) == ex.rd) || (id_use_rs2 && int'(id_rs2) == ex.rd));
      if (mw)                   e_ctl = 5'b11100;
      else if (ex_branch_taken) e_ctl = 5'b00011;
      else if (lu)              e_ctl = 5'b11001;
      else                      e_ctl = 5'b00000;
      e_pend = 32'd0;
      foreach (pipe[j]) if (pipe[j].v && pipe[j].rd != 0) e_pend[pipe[j].rd] = 1'b1;

      chk($sformatf("rnd%0d.ctl", cyc),    64'(ctl),            64'(e_ctl));
      chk($sformatf("rnd%0d.pend", cyc),   64'(pending),        64'(e_pend));
      chk($sformatf("rnd%0d.stall", cyc),  64'(stall_cycles),   64'(m_stall));
      chk($sformatf("rnd%0d.flush", cyc),  64'(flush_count),    64'(m_flush));
      chk($sformatf("rnd%0d.sctl", cyc),   64'(s_ctl),          64'(e_ctl));
      chk($sformatf("rnd%0d.sstall", cyc), 64'(s_stall_cycles), 64'(m_sstall));
      chk($sformatf("rnd%0d.sflush", cyc), 64'(s_flush_count),  64'(m_sflush));
      if (cyc % 250 == 0)
        $display("[TB] random cycle %0d ctl=%b stall=%0d flush=%0d", cyc, ctl,
                 stall_cycles, flush_count);

      if (!mw) begin
        void'(pipe.pop_back());
        if (ex_branch_taken || lu) pipe.push_front('{v: 1'b0, rd: 0, ld: 1'b0});
        else pipe.push_front('{v: id_valid && id_reg_write, rd: int'(id_rd),
                               ld: (id_mem_to_reg == 2'b11)});
      end
      if (e_ctl[4]) begin
        if (m_stall  < 64'hFFFF_FFFF) m_stall++;
        if (m_sstall < 15)            m_sstall++;
      end
      if (e_ctl[1]) begin
        if (m_flush  < 65535) m_flush++;
        if (m_sflush < 15)    m_sflush++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
